// File: rtl/t02_mem_pkg.sv
// ============================================================================
// Module   : t02_mem_pkg
// Brief    : Shared types and default widths for the t02 memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package t02_mem_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } grant_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage

`default_nettype wire

// File: rtl/t02_mem_arb_pick.sv
// ============================================================================
// Module   : t02_mem_arb_pick
// Brief    : Combinational fairness picker between fetch and data requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t02_mem_arb_pick
    import t02_mem_pkg::*;
(
    input  logic    i_imem_ren,
    input  logic    i_dmm_ren,
    input  logic    i_dmm_wen,
    input  grant_t  i_last_grant,
    output logic    o_req_valid,
    output grant_t  o_grant,
    output mem_op_t o_op
);

    always_comb begin
        o_req_valid = i_imem_ren | i_dmm_ren | i_dmm_wen;
        o_grant     = INSTR;
        o_op        = OP_READ;
        // Data wins unless it was served last and a fetch is waiting.
        if ((i_dmm_ren | i_dmm_wen) && !((i_last_grant == DATA) && i_imem_ren)) begin
            o_grant = DATA;
            o_op    = i_dmm_ren ? OP_READ : OP_WRITE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/t02_mem_arbiter.sv
// ============================================================================
// Module   : t02_mem_arbiter
// Brief    : Shares the RAM/bus-manager port between fetch and data requesters.
//            Optional watchdog abort enabled by T02_MEM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t02_mem_arbiter
    import t02_mem_pkg::*;
#(
    parameter int ADDR_W         = c_ADDR_W,
    parameter int DATA_W         = c_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemRen,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmmRen,
    input  logic              dmmWen,
    input  logic [ADDR_W-1:0] dmmaddr,
    input  logic [DATA_W-1:0] dmmstore,
    input  logic              busy_o,
    input  logic [DATA_W-1:0] ramload,
    output logic              Ren,
    output logic              Wen,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    output logic              i_ready,
    output logic              d_ready,
    output logic [DATA_W-1:0] imemload,
    output logic [DATA_W-1:0] dmmload,
    output logic              err
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    grant_t     r_last_grant;
    mem_op_t    r_op;
    grant_t     w_pick_grant;
    mem_op_t    w_pick_op;
    logic       w_req_valid;
    logic       w_abort;
    logic       w_enter_done;

    t02_mem_arb_pick u_pick (
        .i_imem_ren   (imemRen),
        .i_dmm_ren    (dmmRen),
        .i_dmm_wen    (dmmWen),
        .i_last_grant (r_last_grant),
        .o_req_valid  (w_req_valid),
        .o_grant      (w_pick_grant),
        .o_op         (w_pick_op)
    );

`ifdef T02_MEM_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == ISSUE) || (r_state == WAIT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A normal completion in the same cycle takes precedence over the abort.
    assign w_abort = ((r_state == ISSUE) || ((r_state == WAIT) && busy_o)) &&
                     (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign err     = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_abort          = 1'b0;
    assign err              = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_req_valid) w_state_nxt = ISSUE;
            ISSUE: begin
                if (w_abort)     w_state_nxt = DONE;
                else if (busy_o) w_state_nxt = WAIT;
            end
            WAIT:  if (!busy_o || w_abort) w_state_nxt = DONE;
            DONE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_enter_done = ((r_state == ISSUE) || (r_state == WAIT)) && (w_state_nxt == DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_last_grant <= INSTR;
            r_op         <= OP_READ;
            Ren          <= 1'b0;
            Wen          <= 1'b0;
            ramaddr      <= '0;
            ramstore     <= '0;
            i_ready      <= 1'b0;
            d_ready      <= 1'b0;
            imemload     <= '0;
            dmmload      <= '0;
        end else begin
            r_state <= w_state_nxt;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            // The bus registers double as the capture of the granted request.
            if ((r_state == IDLE) && w_req_valid) begin
                r_last_grant <= w_pick_grant;
                r_op         <= w_pick_op;
                Ren          <= (w_pick_op == OP_READ);
                Wen          <= (w_pick_op == OP_WRITE);
                ramaddr      <= (w_pick_grant == DATA) ? dmmaddr : imemaddr;
                ramstore     <= (w_pick_op == OP_WRITE) ? dmmstore : '0;
            end
            if (w_enter_done) begin
                Ren      <= 1'b0;
                Wen      <= 1'b0;
                ramaddr  <= '0;
                ramstore <= '0;
                i_ready  <= (r_last_grant == INSTR);
                d_ready  <= (r_last_grant == DATA);
                if (!w_abort && (r_op == OP_READ)) begin
                    if (r_last_grant == INSTR) imemload <= ramload;
                    else                       dmmload  <= ramload;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_t02_mem_arbiter.sv
// ============================================================================
// Module   : tb_t02_mem_arbiter
// Brief    : Self-checking bench for t02_mem_arbiter with a bus-manager model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t02_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          imemRen, dmmRen, dmmWen, busy_o;
    logic [AW-1:0] imemaddr, dmmaddr, ramaddr;
    logic [DW-1:0] dmmstore, ramload, ramstore, imemload, dmmload;
    logic          Ren, Wen, i_ready, d_ready, err;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference state: who was served last, and what each load port should hold.
    bit            m_last_data;
    logic [DW-1:0] m_iload, m_dload;

    always #5 CLK = ~CLK;

    t02_mem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemRen  (imemRen),
        .imemaddr (imemaddr),
        .dmmRen   (dmmRen),
        .dmmWen   (dmmWen),
        .dmmaddr  (dmmaddr),
        .dmmstore (dmmstore),
        .busy_o   (busy_o),
        .ramload  (ramload),
        .Ren      (Ren),
        .Wen      (Wen),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .i_ready  (i_ready),
        .d_ready  (d_ready),
        .imemload (imemload),
        .dmmload  (dmmload),
        .err      (err)
    );

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; busy_o = 1'b0;
        imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0;
        tick(); tick();
        RST = 1'b0;
        m_last_data = 1'b0;
        m_iload = '0;
        m_dload = '0;
    endtask

    // One full transaction: the bus responds one cycle after seeing the request,
    // stays busy blen cycles, then returns rdata. Served request is dropped on ready.
    task automatic serve(input int lat, input int blen, input logic [DW-1:0] rdata,
                         output bit was_instr);
        bit            exp_instr, exp_wr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_store;
        int            n;
        exp_instr = (m_last_data && imemRen) || !(dmmRen || dmmWen);
        exp_wr    = !exp_instr && !dmmRen;
        exp_addr  = exp_instr ? imemaddr : dmmaddr;
        exp_store = exp_wr ? dmmstore : '0;
        was_instr = exp_instr;
        tick();
        chk("ready_width", {i_ready, d_ready}, 2'b00);
        n = 0;
        while (!(Ren || Wen) && n < 8) begin
            tick();
            n++;
        end
        chk("issue_seen", Ren | Wen, 1);
        m_last_data = !exp_instr;
        // Requester-side churn must not reach the captured bus values.
        dmmaddr  = dmmaddr ^ 32'h0000_0300;
        imemaddr = ~imemaddr;
        dmmstore = ~dmmstore;
        for (int c = 0; c < lat + blen; c++) begin
            chk("bus_hold", {Ren, Wen, ramaddr, ramstore, i_ready, d_ready},
                {!exp_wr, exp_wr, exp_addr, exp_store, 2'b00});
            busy_o = (c >= lat);
            tick();
        end
        chk("bus_hold_end", {Ren, Wen, ramaddr, ramstore, i_ready, d_ready},
            {!exp_wr, exp_wr, exp_addr, exp_store, 2'b00});
        busy_o  = 1'b0;
        ramload = rdata;
        tick();
        chk("ready_sel", {i_ready, d_ready}, {exp_instr, !exp_instr});
        chk("done_bus", {Ren, Wen, err}, 3'b000);
        if (!exp_wr) begin
            if (exp_instr) m_iload = rdata;
            else           m_dload = rdata;
        end
        chk("loads", {imemload, dmmload}, {m_iload, m_dload});
        ramload = $urandom;
        if (exp_instr)   imemRen = 1'b0;
        else if (exp_wr) dmmWen  = 1'b0;
        else begin
            dmmRen = 1'b0;
            if ($urandom_range(0, 1) == 1) dmmWen = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            wi;
        int            n;
        bit            saw;
        imemaddr = '0; dmmaddr = '0; dmmstore = '0; ramload = '0;
        do_reset();

        chk("reset_bus", {Ren, Wen, ramaddr, ramstore, i_ready, d_ready, err}, '0);
        chk("reset_loads", {imemload, dmmload}, '0);

        // Single fetch
        imemRen = 1'b1; imemaddr = 32'h0000_0040;
        serve(1, 3, 32'h0051_3023, wi);
        chk("fetch_load", imemload, 32'h0051_3023);

        // Contention: both sides held, grants must alternate starting with data
        imemRen = 1'b1; dmmRen = 1'b1; dmmWen = 1'b0;
        imemaddr = 32'h0000_1000; dmmaddr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            serve($urandom_range(1, 2), $urandom_range(1, 3), $urandom, wi);
            chk("contention_order", wi, (k % 2));
            imemRen = 1'b1; dmmRen = 1'b1;
        end
        imemRen = 1'b0; dmmRen = 1'b0;

        // Single store
        dmmWen = 1'b1; dmmaddr = 32'h3300_0008; dmmstore = 32'hDEAD_BEEF;
        serve(1, 2, 32'h1234_5678, wi);
        chk("store_dmmload_held", dmmload, m_dload);

        // Address churn one cycle after grant (0x100 -> 0x200 inside serve)
        dmmRen = 1'b1; dmmaddr = 32'h0000_0100;
        serve(1, 2, 32'hCAFE_0001, wi);

        // Reset while a write is in WAIT
        dmmWen = 1'b1; dmmaddr = 32'h0000_0400; dmmstore = 32'h5555_AAAA;
        n = 0;
        tick();
        while (!Wen && n < 8) begin tick(); n++; end
        chk("midrst_issue", Wen, 1);
        busy_o = 1'b1;
        tick(); tick();
        RST = 1'b1;
        tick();
        chk("midrst_outputs", {Ren, Wen, i_ready, d_ready}, 4'b0000);
        RST = 1'b0; dmmWen = 1'b0; busy_o = 1'b0;
        m_last_data = 1'b0; m_iload = '0; m_dload = '0;
        tick();
        chk("midrst_no_ready", {Ren, Wen, i_ready, d_ready}, 4'b0000);
        imemRen = 1'b1; imemaddr = 32'h0000_0080;
        serve(1, 1, 32'h0000_0013, wi);

        // Bus stuck busy
        dmmRen = 1'b1; dmmaddr = 32'h0000_0900;
        n = 0;
        tick();
        while (!Ren && n < 8) begin tick(); n++; end
        chk("stuck_issue", Ren, 1);
        busy_o = 1'b1;
        saw = 1'b0;
`ifdef T02_MEM_TIMEOUT_EN
        n = 0;
        while (!(i_ready || d_ready) && n < TO + 6) begin tick(); n++; end
        chk("timeout_ready_err", {i_ready, d_ready, err}, 3'b011);
        chk("timeout_dmmload_held", dmmload, m_dload);
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            if (i_ready || d_ready || err) saw = 1'b1;
        end
        chk("no_timeout_ready", saw, 1'b0);
`endif
        do_reset();

        // Randomized traffic against the reference model
        for (int it = 0; it < 30; it++) begin
            if (!imemRen && $urandom_range(0, 1) == 1) begin
                imemRen  = 1'b1;
                imemaddr = $urandom;
            end
            if (!(dmmRen || dmmWen) && $urandom_range(0, 1) == 1) begin
                n        = $urandom_range(1, 3);
                dmmRen   = n[0];
                dmmWen   = n[1];
                dmmaddr  = $urandom;
                dmmstore = $urandom;
            end
            if (!(imemRen || dmmRen || dmmWen)) begin
                imemRen  = 1'b1;
                imemaddr = $urandom;
            end
            serve($urandom_range(1, 3), $urandom_range(1, 3), $urandom, wi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/t02_mem_arbiter.md
Name: t02_mem_arbiter

Overview:
- Sequencing arbiter that shares the single RAM/bus-manager port between the instruction-fetch and data-memory requesters of the t02 core.
- Captures a granted request and drives Ren/Wen/ramaddr/ramstore stably for the whole bus transaction.
- Tracks the bus manager's busy_o handshake and returns registered load data with a one-cycle ready pulse.
- Sits between the fetch/load-store units and the bus manager, replacing ad-hoc combinational steering with an explicit FSM and fairness rule.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, max cycles in WAIT before abort; used only with T02_MEM_TIMEOUT_EN.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- imemRen  input  1  instruction read request; held until i_ready.
- imemaddr  input  ADDR_W  instruction address.
- dmmRen  input  1  data read request; held until d_ready.
- dmmWen  input  1  data write request; held until d_ready.
- dmmaddr  input  ADDR_W  data address.
- dmmstore  input  DATA_W  write data.
- busy_o  input  1  bus manager busy; high while a transaction is in flight.
- ramload  input  DATA_W  read data from bus manager, valid on busy_o falling.
- Ren  output  1  bus read enable.
- Wen  output  1  bus write enable.
- ramaddr  output  ADDR_W  bus address.
- ramstore  output  DATA_W  bus write data.
- i_ready  output  1  one-cycle pulse: instruction read done.
- d_ready  output  1  one-cycle pulse: data read/write done.
- imemload  output  DATA_W  last instruction word, held until next i_ready.
- dmmload  output  DATA_W  last data load word, held until next d_ready.
- err  output  1  one-cycle pulse with ready on timeout abort; constant 0 without macro.

Behaviour:
- Reset: all outputs 0. State is IDLE, last_grant=INSTR, and all capture registers are 0.
- States:
  - IDLE: if any request, grant, capture addr/data/op into registers, go to ISSUE.
  - ISSUE: drive captured Ren or Wen, ramaddr and ramstore. On busy_o=1 go to WAIT.
  - WAIT: hold the same bus outputs. On busy_o=0 capture ramload if a read, go to DONE.
  - DONE: bus outputs are 0. Pulse i_ready or d_ready for the granted side, go to IDLE.
- Bus outputs are registered from the capture registers. Later changes on requester inputs have no effect until the next grant.
- Arbitration in IDLE:
  - Data has priority, unless last_grant=DATA and imemRen=1; then the instruction side wins.
  - Under constant contention, the requesters alternate grants.
  - last_grant updates on entry to ISSUE.
- dmmRen and dmmWen both high: treated as read; the write is served on the next data grant if still held.
- Minimum latency: request sampled in IDLE (cycle 0), ISSUE cycle 1, ready pulse in DONE ≥ cycle 4 with a one-cycle busy_o.
- Back-to-back requests lose one IDLE cycle between grants.
- Requester drops its request mid-transaction: the transaction still completes and the ready pulse is still generated. A write is never cancelled once issued.
- imemload/dmmload update only on their own ready cycle; otherwise they hold.
- RST in any state returns to IDLE next edge. Ren/Wen drop, no ready pulse, the in-flight bus transaction is abandoned.
- i_ready and d_ready are never high in the same cycle.

Optional Feature:
- Macro: T02_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter of clog2(TIMEOUT_CYCLES+1) bits clears on entering ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT_CYCLES, go to DONE with err=1 alongside the ready pulse. Load registers are not updated.
- Undefined: no counter; err tied 0; the FSM waits indefinitely.

Decomposition:
- Shared package t02_mem_pkg:
  - enum arb_state_t {IDLE, ISSUE, WAIT, DONE}.
  - enum grant_t {INSTR, DATA}.
  - enum mem_op_t {OP_READ, OP_WRITE}.
  - Constants ADDR_W/DATA_W defaults.
- Sub-module t02_mem_arb_pick: combinational fairness picker (imemRen, dmmRen, dmmWen, last_grant → grant, op).
- FSM and capture registers stay in the top.

Test Plan:
- Single fetch: imemRen=1, imemaddr=0x0000_0040, busy_o high 3 cycles, ramload=0x0051_3023 → Ren=1 with ramaddr=0x40 in ISSUE/WAIT; i_ready one pulse; imemload=0x0051_3023.
- Single store: dmmWen=1, dmmaddr=0x3300_0008, dmmstore=0xDEAD_BEEF → Wen=1, ramstore=0xDEAD_BEEF held through busy_o; d_ready one pulse; dmmload unchanged.
- Contention: imemRen and dmmRen both held continuously over 4 transactions → grant order DATA, INSTR, DATA, INSTR; ready pulses alternate and never overlap.
- Input churn: change dmmaddr from 0x100 to 0x200 one cycle after grant → ramaddr stays 0x100 until DONE.
- Mid-op reset: assert RST during WAIT → next cycle Ren=Wen=0, state IDLE, no ready pulse; a new fetch then completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=8): busy_o stuck high → after 8 cycles d_ready=1 and err=1 same cycle; dmmload unchanged; with macro off, no ready is produced.
